// File: rtl/ss_seq_pkg.sv
// ss_seq_pkg: shared definitions for the save-state sequencer.
//   state_t     - sequencer FSM encoding (also exported on the debug port)
//   CRC_POLY    - CRC-8 polynomial used when SS_CRC_EN is defined
//   SS_LAST_DEF - default last mapper state address walked
//   crc8_step   - folds one byte into a running CRC-8 (MSB first, no reflection)
package ss_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_RD = 3'd1,
    S_BW = 3'd2,
    L_BR = 3'd3,
    L_WE = 3'd4,
    NEXT = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [7:0] CRC_POLY    = 8'h07;
  localparam int         SS_LAST_DEF = 127;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ss_seq_if.sv
// ss_seq_if: mapper state port plus save-state buffer port of the sequencer.
//   Mapper side : ss_act, ss_we, ss_addr, ss_wdat (sequencer -> mapper), ss_rdat (mapper -> sequencer)
//   Buffer side : buf_addr, buf_we, buf_re, buf_wdat (sequencer -> buffer),
//                 buf_rdat, buf_ack (buffer -> sequencer)
//
// Buffer handshake: buf_we (write) and buf_re (read) are request strobes, never
// both high. A request, its address and write data stay stable until the
// buffer answers with a single-cycle buf_ack; the request drops on the clock
// after buf_ack. buf_rdat is valid in the buf_ack cycle. buf_ack without an
// outstanding request carries no meaning and is ignored.
// Mapper port: ss_addr and ss_wdat are stable for the whole time ss_we=1.
//
// Modports: master = sequencer, slave = mapper/buffer side.
interface ss_seq_if;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] buf_addr;
  logic       buf_we;
  logic       buf_re;
  logic [7:0] buf_wdat;
  logic [7:0] buf_rdat;
  logic       buf_ack;

  modport master (
    output ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_we, buf_re, buf_wdat,
    input  ss_rdat, buf_rdat, buf_ack
  );

  modport slave (
    input  ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_we, buf_re, buf_wdat,
    output ss_rdat, buf_rdat, buf_ack
  );
endinterface

// File: rtl/ss_seq_m2_edge_sync.sv
// m2_edge_sync: brings an asynchronous strobe into the clk domain and emits a
// one-clk pulse on each 1->0 transition of the synchronized value.
//   clk, rst (async, active-high) ; m2 : asynchronous input
//   fall : one-cycle pulse per synchronized falling edge
// STAGES must be >= 2. Everything clears to 0 on reset, so an m2 that idles
// high after reset shows a rising edge first and never a false fall.
module m2_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], m2};
      prev <= sync[STAGES-1];
    end
  end

  // prev is an extra flop past the chain so the edge detect never looks at
  // the first (possibly metastable) stage.
  assign fall = prev & ~sync[STAGES-1];

endmodule

// File: rtl/ss_seq.sv
// ss_seq: save-state sequencer in front of a mapper core.
//   Save: walks mapper state addresses 0..SS_LAST, copies each ss_rdat byte to the buffer.
//   Load: reads each buffer byte and strobes it into the mapper across a real m2 negedge.
// Ports:
//   clk, rst (async, active-high), m2 (async CPU M2)
//   cmd_save, cmd_load : one-cycle start pulses (save wins if both)
//   busy, done (one-cycle), err (sticky m2 timeout, cleared by next accepted command)
//   crc       : CRC-8 of transferred bytes when SS_CRC_EN is defined, else 0
//   dbg_state : current FSM state
//   bus       : ss_seq_if.master (mapper state port + buffer port)
// Optional feature macro: SS_CRC_EN.
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int SS_LAST  = SS_LAST_DEF,
  parameter int RD_WAIT  = 2,
  parameter int SYNC_STG = 2,
  parameter int TO_CYC   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] crc,
  output state_t     dbg_state,
  ss_seq_if.master   bus
);

  localparam int RCW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam int TW  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  state_t         state_q, state_d;
  logic [7:0]     addr_q;
  logic [RCW-1:0] rd_cnt;
  logic           fall_seen;
  logic [TW-1:0]  to_cnt;
  logic           is_load;
  logic [7:0]     buf_wdat_q;
  logic [7:0]     ss_wdat_q;
  logic           err_q;
  logic           m2_fall;
  logic           accept;
  logic           rd_last;
  logic           to_hit;
  logic           at_last;

  m2_edge_sync #(.STAGES(SYNC_STG)) u_m2_sync (
    .clk  (clk),
    .rst  (rst),
    .m2   (m2),
    .fall (m2_fall)
  );

  assign accept  = (state_q == IDLE) && (cmd_save || cmd_load);
  assign rd_last = (rd_cnt == RCW'(RD_WAIT - 1));
  // A fall in the final cycle restarts the timer rather than aborting.
  assign to_hit  = !m2_fall && (to_cnt == TW'(TO_CYC - 1));
  assign at_last = (addr_q == 8'(SS_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_save) state_d = S_RD;
            else if (cmd_load) state_d = L_BR;
      S_RD: if (rd_last) state_d = S_BW;
      S_BW: if (bus.buf_ack) state_d = NEXT;
      L_BR: if (bus.buf_ack) state_d = L_WE;
      // The first fall may belong to a negedge that happened before ss_we
      // rose (synchronizer latency); the second one is guaranteed inside.
      L_WE: if (m2_fall && fall_seen) state_d = NEXT;
            else if (to_hit) state_d = FIN;
      NEXT: if (at_last) state_d = FIN;
            else state_d = is_load ? L_BR : S_RD;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the async-reset state register so rst
  // removes ss_act/ss_we immediately, not at the next clock.
  assign busy         = (state_q != IDLE) && (state_q != FIN);
  assign done         = (state_q == FIN);
  assign err          = err_q;
  assign dbg_state    = state_q;
  assign bus.ss_act   = busy;
  assign bus.ss_we    = (state_q == L_WE);
  assign bus.ss_addr  = addr_q;
  assign bus.ss_wdat  = ss_wdat_q;
  assign bus.buf_addr = addr_q;
  assign bus.buf_we   = (state_q == S_BW);
  assign bus.buf_re   = (state_q == L_BR);
  assign bus.buf_wdat = buf_wdat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rd_cnt     <= '0;
      fall_seen  <= 1'b0;
      to_cnt     <= '0;
      is_load    <= 1'b0;
      buf_wdat_q <= '0;
      ss_wdat_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_cnt    <= (state_q == S_RD && !rd_last) ? rd_cnt + 1'b1 : '0;
      fall_seen <= (state_q == L_WE) ? (fall_seen | m2_fall) : 1'b0;
      to_cnt    <= (state_q == L_WE && !m2_fall) ? to_cnt + 1'b1 : '0;
      if (accept) begin
        addr_q  <= '0;
        err_q   <= 1'b0;
        is_load <= !cmd_save;
      end
      if (state_q == S_RD && rd_last) buf_wdat_q <= bus.ss_rdat;
      if (state_q == L_BR && bus.buf_ack) ss_wdat_q <= bus.buf_rdat;
      if (state_q == L_WE && !(m2_fall && fall_seen) && to_hit) err_q <= 1'b1;
      if (state_q == NEXT && !at_last) addr_q <= addr_q + 8'd1;
    end
  end

`ifdef SS_CRC_EN
  logic [7:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else if (accept) begin
      crc_q <= '0;
    end else if (state_q == S_RD && rd_last) begin
      crc_q <= crc8_step(crc_q, bus.ss_rdat);
    end else if (state_q == L_BR && bus.buf_ack) begin
      crc_q <= crc8_step(crc_q, bus.buf_rdat);
    end
  end

  assign crc = crc_q;
`else
  assign crc = '0;
`endif

endmodule

// File: tb/tb_ss_seq.sv
// tb_ss_seq: directed sequence with randomized data for ss_seq.
// Mapper stub: ss_rdat = map_mem[ss_addr]; writes captured on negedge m2 while ss_act&ss_we.
// Buffer stub: acks a request buf_lat clk cycles after it appears.
module tb_ss_seq;
  import ss_seq_pkg::*;

  localparam int SS_LAST = 127;
  localparam int TO_CYC  = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       m2;
  logic       cmd_save;
  logic       cmd_load;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] crc;
  state_t     dbg_state;

  ss_seq_if bus();

  ss_seq #(
    .SS_LAST(SS_LAST), .RD_WAIT(2), .SYNC_STG(2), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .m2(m2), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .busy(busy), .done(done), .err(err), .crc(crc), .dbg_state(dbg_state),
    .bus(bus)
  );

  // ---------------- clock / m2 ----------------
  always #5 clk = ~clk;

  logic m2_run;
  // m2 edges sit at 3 mod 5 ns, so they never coincide with a clk edge.
  initial begin
    m2 = 1'b1;
    #3;
    forever begin
      if (m2_run) begin
        m2 = 1'b1; #35;
        m2 = 1'b0; #35;
      end else begin
        m2 = 1'b1; #10;
      end
    end
  end

  // ---------------- stubs ----------------
  logic [7:0]  map_mem [256];
  logic [7:0]  buf_mem [256];
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int buf_lat = 3;
  int buf_cnt;
  int n_buf_wr = 0, n_buf_rd = 0;
  int n_cap = 0;
  logic [7:0] cap0;

  assign bus.ss_rdat = map_mem[bus.ss_addr];

  always @(negedge clk) begin
    if (rst) begin
      bus.buf_ack = 1'b0;
      buf_cnt = 0;
    end else if (bus.buf_ack) begin
      bus.buf_ack = 1'b0;
      buf_cnt = 0;
    end else if (bus.buf_we || bus.buf_re) begin
      buf_cnt++;
      if (buf_cnt >= buf_lat) begin
        bus.buf_ack = 1'b1;
        if (bus.buf_we) begin
          buf_mem[bus.buf_addr] = bus.buf_wdat;
          got_q.push_back({bus.buf_addr, bus.buf_wdat});
          n_buf_wr++;
        end else begin
          bus.buf_rdat = buf_mem[bus.buf_addr];
          n_buf_rd++;
        end
      end
    end
  end

  always @(negedge m2) begin
    if (!rst && bus.ss_act && bus.ss_we) begin
      map_mem[bus.ss_addr] = bus.ss_wdat;
      n_cap++;
      if (bus.ss_addr == 8'd0) cap0 = bus.ss_wdat;
    end
  end

  // ---------------- monitors ----------------
  int n_done = 0, n_we_cyc = 0, n_both = 0, n_req_cyc = 0, n_we_viol = 0;
  logic       prev_we = 1'b0;
  logic [7:0] prev_addr = '0, prev_wdat = '0;

  always @(negedge clk) begin
    if (done) n_done++;
    if (bus.ss_we) n_we_cyc++;
    if (bus.buf_we && bus.buf_re) n_both++;
    if (bus.buf_we || bus.buf_re) n_req_cyc++;
    if (bus.ss_we && prev_we && (bus.ss_addr != prev_addr || bus.ss_wdat != prev_wdat)) n_we_viol++;
    prev_we   = bus.ss_we;
    prev_addr = bus.ss_addr;
    prev_wdat = bus.ss_wdat;
  end

  // ---------------- reference model ----------------
  // Bit-serial CRC-8, poly x^8+x^2+x+1, init 0, over bytes[lo..hi] of an image.
  function automatic logic [7:0] crc_ref(input logic [7:0] img [256], input int hi);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int a = 0; a <= hi; a++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ img[a][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_crc(input logic [7:0] img [256]);
`ifdef SS_CRC_EN
    return crc_ref(img, SS_LAST);
`else
    return (img[0] === 8'hxx) ? 8'h01 : 8'h00;
`endif
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic pulse_cmd(input logic s, input logic l);
    cmd_save = s;
    cmd_load = l;
    @(negedge clk);
    cmd_save = 1'b0;
    cmd_load = 1'b0;
  endtask

  // Expected save image is simply the mapper contents 0..SS_LAST in order.
  task automatic compare_save(input string tag);
    logic [15:0] got;
    exp_q.delete();
    for (int a = 0; a <= SS_LAST; a++) exp_q.push_back({8'(a), map_mem[a]});
    check({tag, "_count"}, got_q.size(), SS_LAST + 1);
    while (exp_q.size() != 0) begin
      got = (got_q.size() != 0) ? got_q.pop_front() : 16'hFFFF;
      check($sformatf("%s_byte%0d", tag, exp_q[0][15:8]), got, exp_q[0]);
      void'(exp_q.pop_front());
    end
    got_q.delete();
  endtask

  int base_done, base_we, base_rd, base_cap, base_req, k;

  initial begin
    rst = 1'b1; cmd_save = 1'b0; cmd_load = 1'b0; m2_run = 1'b0; cap0 = 8'hFF;
    for (int a = 0; a < 256; a++) begin
      map_mem[a] = 8'h00;
      buf_mem[a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- reset state ----
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ss_act", bus.ss_act, 0);
    check("rst_ss_we", bus.ss_we, 0);
    check("rst_ss_addr", bus.ss_addr, 0);
    check("rst_buf_we", bus.buf_we, 0);
    check("rst_buf_re", bus.buf_re, 0);
    check("rst_crc", crc, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // ---- save: ss_rdat = addr ^ 0xA5, buffer ack after 3 cycles ----
    for (int a = 0; a < 256; a++) map_mem[a] = 8'(a) ^ 8'hA5;
    buf_lat = 3; got_q.delete();
    base_done = n_done; base_we = n_we_cyc;
    pulse_cmd(1'b1, 1'b0);
    check("save_busy", busy, 1);
    check("save_ss_act", bus.ss_act, 1);
    check("save_start_addr", bus.ss_addr, 0);
    wait_done(5000, "save_done");
    check("save_done_act", bus.ss_act, 0);
    check("save_done_busy", busy, 0);
    check("save_err", err, 0);
    check("save_crc", crc, exp_crc(map_mem));
    @(negedge clk);
    check("save_buf0", buf_mem[0], 8'hA5);
    check("save_buf127", buf_mem[127], 8'hDA);
    compare_save("save");
    check("save_done_pulses", n_done - base_done, 1);
    check("save_no_we", n_we_cyc - base_we, 0);
    check("save_crc_held", crc, exp_crc(map_mem));

    // ---- load: random buffer image, byte 0 = 0x05, m2 period 7 clk ----
    for (int a = 0; a < 256; a++) begin
      buf_mem[a] = 8'($urandom_range(0, 255));
      map_mem[a] = 8'h00;
    end
    buf_mem[0] = 8'h05;
    buf_mem[SS_LAST + 1] = 8'hEE;
    buf_lat = $urandom_range(1, 4);
    m2_run = 1'b1;
    repeat (20) @(negedge clk);
    base_done = n_done; base_rd = n_buf_rd; cap0 = 8'hFF;
    pulse_cmd(1'b0, 1'b1);
    check("load_busy", busy, 1);
    wait_done(20000, "load_done");
    check("load_err", err, 0);
    check("load_crc", crc, exp_crc(buf_mem));
    @(negedge clk);
    check("load_cap0", cap0, 8'h05);
    check("load_ctrl_reg", map_mem[0], 8'h05);
    for (int a = 0; a <= SS_LAST; a++) check($sformatf("load_map%0d", a), map_mem[a], buf_mem[a]);
    check("load_past_last", map_mem[SS_LAST + 1], 8'h00);
    check("load_reads", n_buf_rd - base_rd, SS_LAST + 1);
    check("load_done_pulses", n_done - base_done, 1);

    // ---- simultaneous commands, then load while busy ----
    for (int a = 0; a < 256; a++) map_mem[a] = 8'($urandom_range(0, 255));
    buf_lat = $urandom_range(1, 4); got_q.delete();
    base_done = n_done; base_we = n_we_cyc; base_rd = n_buf_rd;
    pulse_cmd(1'b1, 1'b1);
    repeat ($urandom_range(5, 40)) @(negedge clk);
    check("simul_busy_before_load", busy, 1);
    pulse_cmd(1'b0, 1'b1);
    wait_done(5000, "simul_done");
    repeat (10) @(negedge clk);
    compare_save("simul");
    check("simul_no_reads", n_buf_rd - base_rd, 0);
    check("simul_no_we", n_we_cyc - base_we, 0);
    check("simul_done_pulses", n_done - base_done, 1);
    check("simul_idle", busy, 0);

    // ---- timeout: m2 stuck high during load ----
    m2_run = 1'b0;
    repeat (20) @(negedge clk);
    map_mem[0] = 8'h3C; buf_mem[0] = 8'hC3;
    base_cap = n_cap; base_rd = n_buf_rd;
    pulse_cmd(1'b0, 1'b1);
    k = 0;
    while (bus.ss_we !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("to_we_rise", bus.ss_we, 1);
    k = 0;
    while (bus.ss_we === 1'b1 && k < TO_CYC + 10) begin @(negedge clk); k++; end
    check("to_we_cycles", k, TO_CYC);
    check("to_done", done, 1);
    check("to_err", err, 1);
    check("to_ss_act", bus.ss_act, 0);
    check("to_ss_we", bus.ss_we, 0);
    check("to_addr", bus.ss_addr, 0);
    @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_one_read", n_buf_rd - base_rd, 1);
    check("to_not_written", map_mem[0], 8'h3C);
    check("to_no_capture", n_cap - base_cap, 0);
    got_q.delete();
    pulse_cmd(1'b1, 1'b0);
    check("to_err_cleared", err, 0);
    wait_done(5000, "to_save_done");
    check("to_save_err", err, 0);
    @(negedge clk);
    got_q.delete();

    // ---- reset mid-operation while ss_we=1 at addr 40 ----
    m2_run = 1'b1;
    for (int a = 0; a < 256; a++) begin
      buf_mem[a] = 8'($urandom_range(1, 255));
      map_mem[a] = 8'h00;
    end
    buf_lat = $urandom_range(1, 4);
    repeat (20) @(negedge clk);
    pulse_cmd(1'b0, 1'b1);
    k = 0;
    while (!(bus.ss_we === 1'b1 && bus.ss_addr === 8'd40) && k < 5000) begin @(negedge clk); k++; end
    check("rst_mid_reach40", {bus.ss_we, bus.ss_addr}, {1'b1, 8'd40});
    #1 rst = 1'b1;
    #1;
    check("rst_mid_act", bus.ss_act, 0);
    check("rst_mid_we", bus.ss_we, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    base_req = n_req_cyc;
    repeat (50) @(negedge clk);
    check("rst_mid_no_req", n_req_cyc - base_req, 0);
    check("rst_mid_idle", busy, 0);
    check("rst_mid_prev_loaded", map_mem[39], buf_mem[39]);
    check("rst_mid_41_untouched", map_mem[41], 8'h00);
    for (int a = 0; a < 256; a++) map_mem[a] = 8'($urandom_range(0, 255));
    got_q.delete();
    pulse_cmd(1'b1, 1'b0);
    check("rst_restart_addr", bus.ss_addr, 0);
    check("rst_restart_busy", busy, 1);
    wait_done(5000, "rst_restart_done");
    check("rst_restart_crc", crc, exp_crc(map_mem));
    @(negedge clk);
    compare_save("restart");

    // ---- global invariants ----
    check("never_we_and_re", n_both, 0);
    check("we_addr_wdat_stable", n_we_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Save-state sequencer that sits directly upstream of every mapper core, including the discrete-latch mappers.
- Drives the mapper's ss_act/ss_we/ss_addr strobes and consumes its ss_rdat.
- Save: walks mapper state addresses 0..SS_LAST and copies each byte into the save-state buffer.
- Load: reads the buffer back and writes each byte into the mapper. Each mapper write is timed so the byte is captured on a real negedge of m2.

Parameters:
- SS_LAST, 127: last state address walked; map_idx lives here.
- RD_WAIT, 2: clk cycles between an ss_addr change and the ss_rdat capture.
- SYNC_STG, 2: depth of the m2 synchronizer.
- TO_CYC, 4096: clk cycles allowed without an m2 falling edge before abort.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- m2, in, 1: CPU M2, asynchronous to clk.
- cmd_save, in, 1: one-cycle start-save pulse.
- cmd_load, in, 1: one-cycle start-load pulse.
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: sticky; set on m2 timeout, cleared by the next accepted command.
- ss_act, out, 1: to mapper; state access active.
- ss_we, out, 1: to mapper; write strobe.
- ss_addr, out, 8: to mapper; state address.
- ss_wdat, out, 8: data muxed onto cpu_dat at top level while ss_act=1.
- ss_rdat, in, 8: from mapper.
- buf_addr, out, 8: buffer address, equals ss_addr.
- buf_we, out, 1: buffer write request.
- buf_re, out, 1: buffer read request.
- buf_wdat, out, 8: buffer write data.
- buf_rdat, in, 8: buffer read data.
- buf_ack, in, 1: buffer request complete, one cycle.
- crc, out, 8: checksum of transferred bytes (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; m2 synchronizer cleared.
- rst asserted mid-operation aborts at once. ss_act and ss_we drop asynchronously, so no partial mapper write occurs after reset.
- m2 is synchronized through SYNC_STG flops. m2_fall is a one-clk pulse when the synced value goes 1 to 0.
- Command acceptance:
  - Commands are taken only in IDLE; any command while busy is ignored.
  - cmd_save and cmd_load in the same cycle: save wins.
  - Accepting a command sets busy and ss_act, clears err, and sets ss_addr=0.
- State machine:
  - IDLE: on cmd_save go to S_RD; on cmd_load go to L_BR.
  - S_RD: count RD_WAIT cycles, then latch buf_wdat=ss_rdat and go to S_BW.
  - S_BW: hold buf_we=1 until buf_ack, then go to NEXT.
  - L_BR: hold buf_re=1 until buf_ack, then latch ss_wdat=buf_rdat and go to L_WE.
  - L_WE: ss_we=1. Wait for two m2_fall pulses, so at least one full negedge of m2 falls inside the strobe despite synchronizer latency. Then ss_we=0 and go to NEXT.
  - NEXT: if ss_addr==SS_LAST, go to FIN; otherwise ss_addr+1 and return to S_RD (save) or L_BR (load).
  - FIN: ss_act=0, busy=0, done=1 for one cycle, then IDLE.
- ss_act is held continuously from acceptance to FIN. ss_addr changes only in NEXT, never while ss_we=1.
- ss_wdat is stable whenever ss_we=1.
- ss_addr is 8 bits wide and never wraps: the walk terminates at SS_LAST, with SS_LAST<=255.
- buf_we and buf_re are never high together. A request stays high until buf_ack, and buf_ack outside a request is ignored.
- Timeout: a timer in L_WE counts clk cycles since the last m2_fall. On reaching TO_CYC:
  - ss_we=0, err=1, go to FIN (done still pulses).
  - The remaining addresses are not written.
- Save never depends on m2.

Optional Feature:
- Macro: SS_CRC_EN.
- Defined:
  - crc is a CRC-8 (poly 0x07, init 0x00) over every byte moved, in address order. Save uses ss_rdat; load uses buf_rdat.
  - crc is updated on the byte-latch cycle, cleared on command acceptance, and held after done.
- Undefined: crc tied to 0 and no CRC logic is synthesized.

Decomposition:
- Shared package (defs):
  - state encoding: IDLE, S_RD, S_BW, L_BR, L_WE, NEXT, FIN;
  - the CRC polynomial constant;
  - the default SS_LAST.
- One natural sub-module, m2_edge_sync: the synchronizer plus falling-edge pulse. It is reusable by other clk-domain helpers.

Test Plan:
- Save:
  - Stimulus: mapper stub returns ss_rdat=addr^0xA5; buffer acks after 3 cycles; cmd_save.
  - Response: 128 buffer writes with buf_wdat at addr 0 = 0xA5 and at addr 127 = 0xDA; one done pulse; ss_we never 1; err=0.
- Load:
  - Stimulus: buffer preloaded with byte 0x05 at addr 0; m2 period 7 clk; cmd_load.
  - Response: at addr 0, ss_we spans at least one m2 negedge with ss_wdat=0x05; stub control register = 5 after done.
- Simultaneous commands:
  - Stimulus: cmd_save and cmd_load in the same cycle; then cmd_load while busy.
  - Response: save runs; the second command is ignored; exactly one done pulse.
- Timeout:
  - Stimulus: m2 held at 1 during a load.
  - Response: after TO_CYC cycles in L_WE at addr 0, ss_we=0, err=1, done pulses, ss_act=0; the next cmd_save clears err.
- Reset mid-operation:
  - Stimulus: rst pulse while ss_we=1 at addr 40.
  - Response: ss_act, ss_we, busy drop in the same cycle (async); no further buffer requests; a fresh cmd_save restarts at addr 0.
- CRC (SS_CRC_EN only):
  - Stimulus: save of bytes 0x00..0x7F.
  - Response: crc equals the software CRC-8/poly 0x07 of that sequence; crc is 0 in a build without the macro.
